// File: rtl/resp_capture_misr_if.sv
// -----------------------------------------------------------------------------
// resp_capture_misr_if
// Purpose : groups the response-sample input and the raw-sample readout
//           handshake of resp_capture_misr into one bundle.
// Signals :
//   resp_in    - DUT response sample (RESP_W bits)
//   resp_valid - resp_in is valid this cycle
//   out_data   - FIFO head sample (RESP_W bits)
//   out_valid  - FIFO non-empty
//   out_ready  - consumer accepts out_data
// Handshake : a readout transfer happens on every rising clock edge where
//   out_valid && out_ready are both high; out_valid never depends on
//   out_ready, and out_data is stable while out_valid is high and no
//   transfer has occurred. resp_valid has no back-pressure: every sample
//   presented with resp_valid=1 is taken or deliberately ignored.
// Modports : slave  - the capture block (consumes resp_*, drives out_data/valid)
//            master - the environment (drives resp_*, consumes readout)
// -----------------------------------------------------------------------------
interface resp_capture_misr_if #(
    parameter int RESP_W = 2
);
    logic [RESP_W-1:0] resp_in;
    logic              resp_valid;
    logic [RESP_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  resp_in,
        input  resp_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output resp_in,
        output resp_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/resp_capture_misr.sv
// -----------------------------------------------------------------------------
// resp_capture_misr
// Purpose : captures one DUT response sample per applied vector, compacts each
//           sample into a multiple-input signature register (MISR) and buffers
//           the raw samples in a FIFO that drains over a valid/ready port.
// Ports   :
//   clk        - clock, everything on posedge
//   rst        - synchronous active-high reset
//   start      - pulse, begins a new capture run (ignored while capturing)
//   bus        - resp_capture_misr_if.slave: resp_in/resp_valid in,
//                out_data/out_valid/out_ready readout
//   signature  - current MISR value
//   count      - samples captured this run (saturates at VEC_LEN)
//   busy       - FSM in CAPTURE
//   done       - FSM in DONE
//   overflow   - sticky: a sample missed the FIFO because it was full
//   fsm_state  - raw FSM state (0 IDLE, 1 CAPTURE, 2 DONE) for observation
//   pass       - only with RESP_GOLDEN_CHECK_EN: done && signature==GOLDEN_SIG
// Optional feature macro : RESP_GOLDEN_CHECK_EN (adds GOLDEN_SIG and pass).
// -----------------------------------------------------------------------------
module resp_capture_misr #(
    parameter int               RESP_W  = 2,
    parameter int               VEC_LEN = 16,
    parameter int               DEPTH   = 16,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = 16'h1021,
    parameter logic [SIG_W-1:0] SEED    = 16'h0000
`ifdef RESP_GOLDEN_CHECK_EN
    ,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    resp_capture_misr_if.slave             bus,
    output logic [SIG_W-1:0]               signature,
    output logic [$clog2(VEC_LEN+1)-1:0]   count,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [1:0]                     fsm_state
`ifdef RESP_GOLDEN_CHECK_EN
    ,
    output logic                           pass
`endif
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            state_q;
    logic [RESP_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       fill;
    logic [RESP_W-1:0] head_q;
    logic              ovf_q;

    logic              start_ok;
    logic              take;
    logic              pop;
    logic              full;
    logic              push;
    logic [SIG_W-1:0]  sig_next;
    logic [CNT_W-1:0]  count_next;
    logic [AW-1:0]     rd_next;
    logic [AW:0]       fill_next;
    logic [RESP_W-1:0] head_next;

    always_comb begin
        start_ok   = start && (state_q != S_CAPTURE);
        take       = (state_q == S_CAPTURE) && bus.resp_valid;
        pop        = (fill != '0) && bus.out_ready;
        full       = (fill == (AW+1)'(DEPTH));
        // A pop in the same cycle frees the slot the push needs.
        push       = take && (!full || pop);
        sig_next   = (signature << 1)
                   ^ (signature[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(bus.resp_in);
        count_next = (count == CNT_W'(VEC_LEN)) ? count : count + 1'b1;
        rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
        fill_next  = fill + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        // out_data is a register, so precompute the head after this edge.
        // If the FIFO is empty after the pop, the sample being pushed becomes
        // the head and must bypass the memory.
        head_next  = '0;
        if (fill_next != '0) begin
            if (push && (wr_ptr == rd_next)) begin
                head_next = bus.resp_in;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Storage has no reset; validity is tracked by the pointers and fill.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= bus.resp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            signature <= SEED;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            head_q    <= '0;
            ovf_q     <= 1'b0;
`ifdef RESP_GOLDEN_CHECK_EN
            pass      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (take && (count_next == CNT_W'(VEC_LEN))) state_q <= S_DONE;
                end
                S_DONE: begin
                    if (start) state_q <= S_CAPTURE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (start_ok) begin
                // New run: the flush wins over any pop requested this cycle.
                signature <= SEED;
                count     <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                fill      <= '0;
                head_q    <= '0;
                ovf_q     <= 1'b0;
`ifdef RESP_GOLDEN_CHECK_EN
                pass      <= 1'b0;
`endif
            end else begin
                if (take) begin
                    signature <= sig_next;
                    count     <= count_next;
`ifdef RESP_GOLDEN_CHECK_EN
                    // Set together with the move to DONE; signature then holds.
                    pass      <= (count_next == CNT_W'(VEC_LEN)) && (sig_next == GOLDEN_SIG);
`endif
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (take && !push) begin
                    ovf_q <= 1'b1;
                end
                rd_ptr <= rd_next;
                fill   <= fill_next;
                head_q <= head_next;
            end
        end
    end

    assign bus.out_data  = head_q;
    assign bus.out_valid = (fill != '0);
    assign busy          = (state_q == S_CAPTURE);
    assign done          = (state_q == S_DONE);
    assign overflow      = ovf_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_resp_capture_misr.sv
// -----------------------------------------------------------------------------
// tb_resp_capture_misr
// Bench for resp_capture_misr with a small FIFO (DEPTH=4) and short runs
// (VEC_LEN=8) so overflow, pointer wrap and run completion all occur often.
// A reference model at posedge keeps the samples of the current run and the
// expected FIFO contents as queues; a monitor at negedge compares the DUT
// against it and pops the expected queue on every readout transfer.
// Build with +define+RESP_GOLDEN_CHECK_EN to also check the pass output.
// -----------------------------------------------------------------------------
module tb_resp_capture_misr;
    localparam int               RESP_W  = 2;
    localparam int               VEC_LEN = 8;
    localparam int               DEPTH   = 4;
    localparam int               SIG_W   = 16;
    localparam logic [SIG_W-1:0] POLY    = 16'h1021;
    localparam logic [SIG_W-1:0] SEED    = 16'h5A5A;
    localparam int               CNT_W   = $clog2(VEC_LEN + 1);

    // Signature of the known run whose sample i is i mod 4.
    function automatic logic [SIG_W-1:0] golden_fn();
        int unsigned s;
        s = SEED;
        for (int i = 0; i < VEC_LEN; i++) begin
            s = ((s << 1) & 32'hFFFF) ^ (((s & 32'h8000) != 0) ? POLY : 0) ^ (i % 4);
        end
        return s[SIG_W-1:0];
    endfunction
    localparam logic [SIG_W-1:0] GOLDEN = golden_fn();

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start;
    logic [SIG_W-1:0]  signature;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [1:0]        fsm_state;
`ifdef RESP_GOLDEN_CHECK_EN
    logic              pass;
`endif

    resp_capture_misr_if #(.RESP_W(RESP_W)) bus ();

    resp_capture_misr #(
        .RESP_W    (RESP_W),
        .VEC_LEN   (VEC_LEN),
        .DEPTH     (DEPTH),
        .SIG_W     (SIG_W),
        .POLY      (POLY),
        .SEED      (SEED)
`ifdef RESP_GOLDEN_CHECK_EN
        ,
        .GOLDEN_SIG(GOLDEN)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .signature (signature),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .fsm_state (fsm_state)
`ifdef RESP_GOLDEN_CHECK_EN
        ,
        .pass      (pass)
`endif
    );

    // ---------------- scoreboard state ----------------
    int unsigned       errors = 0;
    int unsigned       checks = 0;
    logic [RESP_W-1:0] exp_q[$];   // expected FIFO contents, head first
    logic [RESP_W-1:0] run_q[$];   // every sample accepted in the current run
    bit                m_run  = 0;
    bit                m_done = 0;
    bit                m_ovf  = 0;
    bit                chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // MISR of the whole run, recomputed from the sample list.
    function automatic logic [SIG_W-1:0] model_sig();
        int unsigned s;
        s = SEED;
        foreach (run_q[i]) begin
            s = ((s << 1) & 32'hFFFF) ^ (((s & 32'h8000) != 0) ? POLY : 0) ^ run_q[i];
        end
        return s[SIG_W-1:0];
    endfunction

    // Reference model: advances on the same edge as the DUT. Any pop for this
    // edge has already been removed from exp_q by the monitor, so a push fits
    // exactly when fewer than DEPTH entries remain.
    always @(posedge clk) begin
        if (rst) begin
            m_run  = 0;
            m_done = 0;
            m_ovf  = 0;
            run_q.delete();
            exp_q.delete();
            chk_en = 1;
        end else if (start && !m_run) begin
            m_run  = 1;
            m_done = 0;
            m_ovf  = 0;
            run_q.delete();
            exp_q.delete();
        end else if (m_run && bus.resp_valid) begin
            run_q.push_back(bus.resp_in);
            if (exp_q.size() < DEPTH) exp_q.push_back(bus.resp_in);
            else                      m_ovf = 1;
            if (run_q.size() == VEC_LEN) begin
                m_run  = 0;
                m_done = 1;
            end
        end
    end

    // Monitor: compares all outputs mid-cycle; a transfer pops exp_q.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            check("signature", 32'(signature), 32'(model_sig()));
            check("count",     32'(count),     32'(run_q.size()));
            check("busy",      32'(busy),      32'(m_run));
            check("done",      32'(done),      32'(m_done));
            check("overflow",  32'(overflow),  32'(m_ovf));
`ifdef RESP_GOLDEN_CHECK_EN
            check("pass",      32'(pass),      32'(m_done && (model_sig() == GOLDEN)));
`endif
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit st, input bit rv, input logic [RESP_W-1:0] d, input bit rdy);
        start          = st;
        bus.resp_valid = rv;
        bus.resp_in    = d;
        bus.out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, RESP_W'($urandom_range(0, 3)), rdy);
    endtask

    task automatic samples(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 1, RESP_W'($urandom_range(0, 3)), rdy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [RESP_W-1:0] d;
        rst = 1'b1;
        start = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_in = '0;
        bus.out_ready = 1'b0;

        // Reset for two cycles with resp_valid toggling, then idle with no start.
        cyc(0, 1, 2'b11, 0);
        cyc(0, 0, 2'b01, 0);
        rst = 1'b0;
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_signature", 32'(signature), 32'(SEED));
        for (int i = 0; i < 4; i++) cyc(0, i[0], RESP_W'($urandom_range(0, 3)), 0);

        // Basic MISR: sample with start is dropped, then 11, 01 drained live.
        cyc(1, 1, 2'b10, 0);
        cyc(0, 1, 2'b11, 1);
        cyc(0, 1, 2'b01, 1);
        idle(3, 1);
        samples(VEC_LEN - 2, 1);
        idle(2, 1);

        // Full run with no draining: overflow after the 5th sample, extra
        // resp_valid after done ignored, then drain the first DEPTH samples.
        cyc(1, 0, 2'b00, 0);
        for (int i = 0; i < VEC_LEN; i++) cyc(0, 1, 2'b10 ^ RESP_W'(i), 0);
        cyc(0, 1, 2'b11, 0);
        idle(DEPTH + 2, 1);

        // Same run but out_ready=1 from the 5th push on: no overflow.
        cyc(1, 0, 2'b00, 0);
        samples(DEPTH, 0);
        samples(VEC_LEN - DEPTH, 1);
        idle(DEPTH + 1, 1);

        // Mid-run reset after 5 samples, then restart.
        cyc(1, 0, 2'b00, 0);
        samples(5, 0);
        rst = 1'b1;
        cyc(0, 1, 2'b01, 0);
        rst = 1'b0;
        idle(2, 0);

        // Run to DONE leaving stale FIFO entries; start in DONE flushes them
        // while a drain is requested in the same cycle.
        cyc(1, 0, 2'b00, 0);
        samples(VEC_LEN, 0);
        idle(1, 0);
        cyc(1, 1, 2'b11, 1);
        samples(3, 0);
        rst = 1'b1;
        cyc(0, 0, 2'b00, 0);
        rst = 1'b0;

        // Known sequence (golden), then the same with one bit flipped.
        cyc(1, 0, 2'b00, 1);
        for (int i = 0; i < VEC_LEN; i++) cyc(0, 1, RESP_W'(i % 4), 1);
        idle(2, 1);
        cyc(1, 0, 2'b00, 1);
        for (int i = 0; i < VEC_LEN; i++) begin
            d = RESP_W'(i % 4);
            if (i == 3) d[0] = ~d[0];
            cyc(0, 1, d, 1);
        end
        idle(2, 1);

        // Random traffic with occasional start and reset.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1,
                RESP_W'($urandom_range(0, 3)),
                $urandom_range(0, 2) != 0);
        end
        rst = 1'b0;
        idle(DEPTH + 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/resp_capture_misr.md
Name: resp_capture_misr

Overview:
- Response-side companion to the vector-apply bench flow: samples DUT primary outputs, e.g. c17 N22/N23, once per applied vector.
- Compacts every sample into a multiple-input signature register (MISR), buffers raw samples in a FIFO, and exposes them over a valid/ready readout port.
- Replaces per-vector file dumps with a synthesizable capture path, so aged and fresh netlists can be compared by signature or by drained raw responses.

Parameters:
RESP_W, 2, width of one DUT response sample
VEC_LEN, 16, number of samples captured per run
DEPTH, 16, FIFO entries (power of two, >=2)
SIG_W, 16, MISR width (>= RESP_W)
POLY, 16'h1021, MISR feedback polynomial (taps XORed when MSB shifts out)
SEED, 16'h0000, MISR value loaded on reset and on start
GOLDEN_SIG, 16'h0000, expected signature (used only with optional feature)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  begin new capture run (pulse)
resp_in  in  RESP_W  DUT response sample
resp_valid  in  1  resp_in valid this cycle
out_data  out  RESP_W  FIFO head sample
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data
signature  out  SIG_W  current MISR value
count  out  clog2(VEC_LEN+1)  samples captured this run
busy  out  1  FSM in CAPTURE
done  out  1  FSM in DONE
overflow  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at posedge) forces every output to a defined value:
  - FSM=IDLE, signature=SEED, count=0, FIFO empty.
  - out_valid=0, out_data=0, busy=0, done=0, overflow=0.
  - Reset mid-run aborts the run; no partial state survives.
- FSM states IDLE, CAPTURE, DONE:
  - IDLE --start--> CAPTURE.
  - CAPTURE --accepted sample with count reaching VEC_LEN--> DONE.
  - DONE --start--> CAPTURE.
  - start while in CAPTURE is ignored.
- start accepted (IDLE or DONE):
  - Next cycle: signature=SEED, count=0, FIFO flushed, overflow=0, busy=1, done=0.
  - A resp_valid in the same cycle as start is not captured.
- Capture: in CAPTURE, each cycle with resp_valid=1:
  - signature <= (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended resp_in.
  - count increments.
  - resp_in is pushed to the FIFO.
  - Results are visible the next cycle.
- resp_valid outside CAPTURE is ignored: no MISR update, no count, no push.
- Run end: the VEC_LENth accepted sample moves the FSM to DONE in the same update. busy=0 and done=1 from the next cycle. done holds until start or rst.
- FIFO:
  - out_valid = !empty; out_data = head entry, registered.
  - Pop occurs when out_valid && out_ready.
  - A push becomes visible on out_valid one cycle later.
  - Push while full with no simultaneous pop: sample dropped from the FIFO only (still compacted into MISR and counted), overflow set sticky.
  - Push and pop while full: both succeed, no overflow.
  - Pointers wrap modulo DEPTH.
  - Draining is allowed in any state; the flush at start overrides a simultaneous pop.
- count saturates at VEC_LEN; signature holds in IDLE and DONE.

Optional Feature:
- Macro RESP_GOLDEN_CHECK_EN.
- Defined: adds output port pass (1 bit).
  - pass=1 iff done=1 and signature==GOLDEN_SIG, registered.
  - pass=0 on reset, during CAPTURE and in IDLE.
- Undefined: no pass port, no comparator logic; GOLDEN_SIG unused.

Test Plan:
1. Reset then idle: rst 2 cycles, resp_valid toggling, no start -> signature=0x0000, count=0, out_valid=0, busy=0, done=0.
2. Basic MISR: start, then samples 2'b11, 2'b01 -> signature 0x0003 then 0x0007, count 1 then 2, FIFO drains 3 then 1 with out_ready=1.
3. Full run with VEC_LEN=16, DEPTH=16, out_ready=0: 16 samples of 2'b10 -> done=1 and busy=0 one cycle after the 16th sample, count=16, overflow=0, 16 entries readable in order. A 17th resp_valid is ignored.
4. Overflow: DEPTH=4, VEC_LEN=8, out_ready=0, 8 samples -> overflow=1 after the 5th, FIFO holds the first 4, count=8, signature equals the full 8-sample MISR. Repeat with out_ready=1 on the 5th push cycle -> overflow stays 0.
5. Mid-run reset and restart: rst after 5 samples -> all cleared. start pulse in DONE with stale FIFO contents -> FIFO empty, signature=SEED next cycle. Sample presented with start is not counted.
6. With RESP_GOLDEN_CHECK_EN: GOLDEN_SIG set to the MISR of a known 16-vector sequence -> pass=1 after done. Flip one sample bit -> pass=0. Build without the macro compiles with no pass port.
